// File: rtl/pc_sequencer.sv
// Program-counter sequencer: in-order fetch addresses with conditional jumps,
// a one-cycle flush bubble after each jump, a stall input, and halt/resume.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | out of reset, waiting for the first enable; pc parked at 0
// S_RUN   | normal sequencing: increment, jump, stall or halt
// S_FLUSH | single bubble cycle after a jump; pc already holds target
// S_HALT  | frozen until resume is seen while halt is low
module pc_sequencer #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [1:0]      cond_sel,
  input  logic            a0,
  input  logic            b0,
  input  logic [PC_W-1:0] target,
  input  logic            status_in,
  input  logic            status_we,
  input  logic            halt,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            jump_taken,
  output logic            wrap,
  output logic            status_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic            valid_nx;
  logic            jump_nx;
  logic            wrap_nx;
  logic            status_nx;
  logic            take;

  // Jump condition, always evaluated against the flag value before any write
  // arriving in the same cycle.
  always_comb begin
    take = 1'b0;
    case (cond_sel)
      2'b00:   take = 1'b0;
      2'b01:   take = 1'b1;
      2'b10:   take = ~status_q & ~a0 & b0;
      default: take = status_q & a0;
    endcase
  end

  // Next state and next registered outputs; halt outranks jump outranks increment.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    valid_nx  = 1'b0;
    jump_nx   = 1'b0;
    wrap_nx   = 1'b0;
    status_nx = status_we ? status_in : status_q;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nx = S_RUN;
          pc_nx    = '0;
          valid_nx = 1'b1;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_nx = S_HALT;
        end else if (enable) begin
          if (take) begin
            state_nx = S_FLUSH;
            pc_nx    = target;
            jump_nx  = 1'b1;
          end else begin
            pc_nx    = pc + 1'b1;
            wrap_nx  = &pc;
            valid_nx = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // The bubble always completes; a pending halt is honoured afterwards.
        if (halt) begin
          state_nx = S_HALT;
        end else begin
          state_nx = S_RUN;
          valid_nx = 1'b1;
        end
      end
      S_HALT: begin
        if (resume && !halt) begin
          state_nx = S_RUN;
          valid_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      pc_valid   <= 1'b0;
      jump_taken <= 1'b0;
      wrap       <= 1'b0;
      status_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      pc_valid   <= valid_nx;
      jump_taken <= jump_nx;
      wrap       <= wrap_nx;
      status_q   <= status_nx;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver applies inputs on the falling
// edge and queues the outputs a behavioural model predicts for the next rising
// edge; an independent monitor compares them just after that edge.
module tb_pc_sequencer;
  localparam int PC_W = 4;
  localparam int NPC  = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            enable = 1'b0;
  logic [1:0]      cond_sel = 2'b00;
  logic            a0 = 1'b0;
  logic            b0 = 1'b0;
  logic [PC_W-1:0] target = '0;
  logic            status_in = 1'b0;
  logic            status_we = 1'b0;
  logic            halt = 1'b0;
  logic            resume = 1'b0;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            jump_taken;
  logic            wrap;
  logic            status_q;

  pc_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cond_sel(cond_sel),
    .a0(a0), .b0(b0), .target(target), .status_in(status_in),
    .status_we(status_we), .halt(halt), .resume(resume), .pc(pc),
    .pc_valid(pc_valid), .jump_taken(jump_taken), .wrap(wrap),
    .status_q(status_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            v;
    logic            jt;
    logic            wr;
    logic            st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural reference: phase of operation plus plain integer pc.
  typedef enum int {M_IDLE, M_RUN, M_FLUSH, M_HALT} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_pc = 0;
  bit      m_v = 0, m_jt = 0, m_wr = 0, m_st = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_pc = 0; m_v = 0; m_jt = 0; m_wr = 0; m_st = 0;
  endtask

  task automatic model_step_and_push();
    bit   cond;
    exp_t e;
    case (cond_sel)
      2'd0: cond = 0;
      2'd1: cond = 1;
      2'd2: cond = !m_st && !a0 && b0;
      default: cond = m_st && a0;
    endcase
    m_jt = 0; m_wr = 0; m_v = 0;
    case (m_phase)
      M_IDLE:  if (enable) begin m_phase = M_RUN; m_pc = 0; m_v = 1; end
      M_RUN: begin
        if (halt) m_phase = M_HALT;
        else if (enable && cond) begin
          m_pc = int'(target); m_jt = 1; m_phase = M_FLUSH;
        end else if (enable) begin
          m_wr = (m_pc == NPC - 1);
          m_pc = (m_pc + 1) % NPC;
          m_v  = 1;
        end
      end
      M_FLUSH: if (halt) m_phase = M_HALT; else begin m_phase = M_RUN; m_v = 1; end
      default: if (resume && !halt) begin m_phase = M_RUN; m_v = 1; end
    endcase
    if (status_we) m_st = status_in;
    e.pc = m_pc[PC_W-1:0]; e.v = m_v; e.jt = m_jt; e.wr = m_wr; e.st = m_st;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit en, input logic [1:0] cs, input bit a, input bit b,
                       input int tgt, input bit swe, input bit sin, input bit h,
                       input bit r);
    @(negedge clk);
    enable = en; cond_sel = cs; a0 = a; b0 = b; target = tgt[PC_W-1:0];
    status_we = swe; status_in = sin; halt = h; resume = r;
    model_step_and_push();
  endtask

  // Reset pulse placed between clock edges, then the cycle's inputs are queued.
  task automatic reset_pulse(input bit en);
    @(negedge clk);
    enable = en; cond_sel = 2'd0; halt = 0; resume = 0; status_we = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", int'(pc), 0);
    chk("async_rst_valid", int'(pc_valid), 0);
    chk("async_rst_jump", int'(jump_taken), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    chk("async_rst_status", int'(status_q), 0);
    #1 rst_n = 1'b1;
    model_reset();
    model_step_and_push();
  endtask

  task automatic jump_to(input int tgt);
    drive(1, 2'd1, 0, 0, tgt, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every cycle that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", int'(pc), int'(e.pc));
        chk("pc_valid", int'(pc_valid), int'(e.v));
        chk("jump_taken", int'(jump_taken), int'(e.jt));
        chk("wrap", int'(wrap), int'(e.wr));
        chk("status_q", int'(status_q), int'(e.st));
        chk("jump_wrap_exclusive", int'(jump_taken & wrap), 0);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset_pc", int'(pc), 0);
    chk("reset_valid", int'(pc_valid), 0);
    chk("reset_status", int'(status_q), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Free-running count through one wrap.
    repeat (18) drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    // Jump-if-clear taken with flag clear.
    jump_to(3);
    drive(1, 2'd2, 0, 1, 9, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    // Flag written in the jump cycle: old value decides, new value blocks the next one.
    jump_to(3);
    drive(1, 2'd2, 0, 1, 9, 1, 1, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    jump_to(3);
    drive(1, 2'd2, 0, 1, 9, 0, 0, 0, 0);
    drive(1, 2'd3, 1, 0, 12, 1, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    // Halt beats a jump, then resume.
    jump_to(5);
    drive(1, 2'd1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    // Stall for three cycles.
    jump_to(7);
    repeat (3) drive(0, 2'd1, 0, 0, 2, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    // Jump to the current pc, then halt arriving during the flush.
    drive(1, 2'd1, 0, 0, 8, 0, 0, 0, 0);
    drive(0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during a flush.
    drive(1, 2'd1, 0, 0, 11, 1, 1, 0, 0);
    reset_pulse(0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        reset_pulse(1'($urandom_range(0, 1)));
      else
        drive($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, NPC - 1)), $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
